// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the DLX pipeline stages and the stall/flush sequencer.
// The pipeline side drives hazard info (master); the sequencer drives the enables and statistics (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    logic [4:0]       rd_ex;
    logic             load_ex;
    logic             pc_cmd_ex;
    logic             pc_cmd_id;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             bubble_ex;
    logic             flush_if;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             stall_lu;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, load_ex,
               pc_cmd_ex, pc_cmd_id, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, bubble_ex, flush_if, ex_mem_en,
               mem_wb_en, stall_lu, mem_timeout_err, stall_count, flush_count
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, load_ex,
               pc_cmd_ex, pc_cmd_id, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, bubble_ex, flush_if, ex_mem_en,
               mem_wb_en, stall_lu, mem_timeout_err, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage DLX pipeline: load-use stalls, branch/jump flushes,
// data-memory wait states with timeout, and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
    logic [CNT_W-1:0]  stall_count_reg, stall_count_next;
    logic [CNT_W-1:0]  flush_count_reg, flush_count_next;
    logic              timeout_err_reg, timeout_err_next;

    logic [4:0] src_id [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;
    logic       lu_hazard;
    logic       freeze;
    logic       running;
    logic       branch_fire;
    logic       lu_fire;
    logic       jump_fire;

    assign src_id[0]   = bus.rs1_id;
    assign src_id[1]   = bus.rs2_id;
    assign src_used[0] = bus.rs1_used_id;
    assign src_used[1] = bus.rs2_used_id;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_hit[gi] = src_used[gi] && (src_id[gi] == bus.rd_ex);
        end
    endgenerate

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign lu_hazard = bus.load_ex && (bus.rd_ex != 5'd0) && (|src_hit);

    assign freeze = ((state_reg == RUN) && bus.mem_req && !bus.mem_ready) ||
                    ((state_reg == MEM_WAIT) && !bus.mem_ready);

    assign running     = (state_reg != ERROR) && !freeze;
    assign branch_fire = running && bus.pc_cmd_ex;
    assign lu_fire     = running && !bus.pc_cmd_ex && lu_hazard;
    assign jump_fire   = running && !bus.pc_cmd_ex && !lu_hazard && bus.pc_cmd_id;

    always_comb begin
        bus.pc_en     = 1'b0;
        bus.if_id_en  = 1'b0;
        bus.id_ex_en  = 1'b0;
        bus.ex_mem_en = 1'b0;
        bus.mem_wb_en = 1'b0;
        bus.flush_if  = 1'b0;
        bus.bubble_ex = 1'b0;
        bus.stall_lu  = 1'b0;
        if (!reset && running) begin
            bus.id_ex_en  = 1'b1;
            bus.ex_mem_en = 1'b1;
            bus.mem_wb_en = 1'b1;
            // a load-use stall holds PC and IF/ID; a pending jump in ID retries next cycle
            bus.pc_en     = !lu_fire;
            bus.if_id_en  = !lu_fire;
            bus.flush_if  = branch_fire || jump_fire;
            bus.bubble_ex = branch_fire || lu_fire;
            bus.stall_lu  = lu_fire;
        end
    end

    assign wait_cnt_inc = wait_cnt_reg + WAIT_ONE;

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        timeout_err_next = timeout_err_reg;
        case (state_reg)
            RUN: begin
                if (freeze) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    // saturate so a disabled timeout never wraps the counter
                    wait_cnt_next = (&wait_cnt_reg) ? wait_cnt_reg : wait_cnt_inc;
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_inc == WAIT_LIMIT)) begin
                        state_next       = ERROR;
                        timeout_err_next = 1'b1;
                    end
                end
            end
            ERROR: state_next = ERROR;
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        flush_count_next = flush_count_reg;
        if ((freeze || lu_fire) && !(&stall_count_reg)) begin
            stall_count_next = stall_count_reg + CNT_ONE;
        end
        if (branch_fire && !(&flush_count_reg)) begin
            flush_count_next = flush_count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            stall_count_reg <= stall_count_next;
            flush_count_reg <= flush_count_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign bus.mem_timeout_err = timeout_err_reg;
    assign bus.stall_count     = stall_count_reg;
    assign bus.flush_count     = flush_count_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch/jump flushes, memory waits,
// timeout into ERROR with recovery by reset, and statistics saturation.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERROR    = 2'd2;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, flush_if, bubble_ex, stall_lu}
    localparam logic [7:0] C_OFF  = 8'b00000_000;
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_011;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_JMP  = 8'b11111_100;

    logic clk = 1'b0;
    logic reset;
    int   check_cnt = 0;
    int   err_cnt   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] ctrl_vec;
    assign ctrl_vec = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                       bus.mem_wb_en, bus.flush_if, bus.bubble_ex, bus.stall_lu};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic ld,
                          input logic pex, input logic pid, input logic mreq,
                          input logic mrdy);
        bus.rs1_id      = rs1;
        bus.rs1_used_id = u1;
        bus.rs2_id      = rs2;
        bus.rs2_used_id = u2;
        bus.rd_ex       = rd;
        bus.load_ex     = ld;
        bus.pc_cmd_ex   = pex;
        bus.pc_cmd_id   = pid;
        bus.mem_req     = mreq;
        bus.mem_ready   = mrdy;
    endtask

    task automatic set_idle();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // check the combinational controls mid-cycle, then advance past the next rising edge
    task automatic run_cycle(input string tag, input logic [7:0] exp_ctrl);
        @(negedge clk);
        check_val(tag, 32'(ctrl_vec), 32'(exp_ctrl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        run_cycle("rst_ctrl", C_OFF);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_idle();
        run_cycle("rst_ctrl0", C_OFF);
        // outputs stay off during reset even with active hazard inputs
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run_cycle("rst_ctrl1", C_OFF);
        reset = 1'b0;
        check_val("rst_stall", 32'(bus.stall_count), 0);
        check_val("rst_flush", 32'(bus.flush_count), 0);
        check_val("rst_err", 32'(bus.mem_timeout_err), 0);
        check_val("rst_state", 32'(dut.state_reg), 32'(S_RUN));
        set_idle();
        run_cycle("idle", C_RUN);

        // load-use on rs1
        set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle("lu_rs1", C_LU);
        check_val("lu_rs1_stall", 32'(bus.stall_count), 1);
        set_in(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle("lu_r0", C_RUN);
        check_val("lu_r0_stall", 32'(bus.stall_count), 1);
        set_in(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle("lu_rs2", C_LU);
        set_in(5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle("lu_unused", C_RUN);
        set_in(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle("no_load", C_RUN);
        set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle("lu_jmp", C_LU);
        check_val("lu_stall3", 32'(bus.stall_count), 3);

        // branch beats load-use and jump
        set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle("br_all", C_BR);
        check_val("br_flush", 32'(bus.flush_count), 1);
        check_val("br_stall", 32'(bus.stall_count), 3);
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle("jmp", C_JMP);
        check_val("jmp_flush", 32'(bus.flush_count), 1);

        // memory wait: three frozen cycles then release
        do_reset();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_cycle("mem_fast", C_RUN);
        check_val("mem_fast_state", 32'(dut.state_reg), 32'(S_RUN));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle($sformatf("mw_frz%0d", i), C_OFF);
            check_val($sformatf("mw_state%0d", i), 32'(dut.state_reg), 32'(S_MEM_WAIT));
        end
        bus.mem_ready = 1'b1;
        run_cycle("mw_release", C_RUN);
        check_val("mw_rel_state", 32'(dut.state_reg), 32'(S_RUN));
        check_val("mw_stall", 32'(bus.stall_count), 3);

        // branch held through a 2-cycle wait is serviced on release only
        do_reset();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle("fb_frz0", C_OFF);
        run_cycle("fb_frz1", C_OFF);
        check_val("fb_flush_hold", 32'(bus.flush_count), 0);
        bus.mem_ready = 1'b1;
        run_cycle("fb_release", C_BR);
        check_val("fb_flush", 32'(bus.flush_count), 1);
        check_val("fb_stall", 32'(bus.stall_count), 2);

        // timeout: four frozen cycles then ERROR until reset
        do_reset();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle($sformatf("to_frz%0d", i), C_OFF);
            check_val($sformatf("to_err%0d", i), 32'(bus.mem_timeout_err), 0);
        end
        run_cycle("to_frz3", C_OFF);
        check_val("to_err", 32'(bus.mem_timeout_err), 1);
        check_val("to_state", 32'(dut.state_reg), 32'(S_ERROR));
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_cycle("err_hold0", C_OFF);
        run_cycle("err_hold1", C_OFF);
        check_val("err_stall", 32'(bus.stall_count), 4);
        check_val("err_flush", 32'(bus.flush_count), 0);
        check_val("err_sticky", 32'(bus.mem_timeout_err), 1);
        reset = 1'b1;
        run_cycle("err_rst", C_OFF);
        reset = 1'b0;
        check_val("err_rst_state", 32'(dut.state_reg), 32'(S_RUN));
        check_val("err_rst_err", 32'(bus.mem_timeout_err), 0);
        check_val("err_rst_stall", 32'(bus.stall_count), 0);
        set_idle();
        run_cycle("err_rst_run", C_RUN);

        // stall counter saturates at all-ones
        do_reset();
        set_in(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            run_cycle($sformatf("sat_lu%0d", i), C_LU);
            check_val($sformatf("sat_cnt%0d", i), 32'(bus.stall_count), (i > 15) ? 15 : i);
        end
        set_idle();
        run_cycle("final_idle", C_RUN);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end
endmodule
